// File: rtl/spi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_ctrl : register-mapped SPI mode-0 master (8-bit, MSB first)            |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs,
  output logic        irq
);

  localparam logic [1:0]       ADDR_CTRL   = 2'd0;
  localparam logic [1:0]       ADDR_DATA   = 2'd1;
  localparam logic [1:0]       ADDR_STATUS = 2'd2;
  localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    TAIL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_q, rx_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             cs_force_q, cs_force_d;
  logic             irq_en_q, irq_en_d;
  logic             ready_q, ready_d;
  logic             acked_q, acked_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             spi_clk_q, spi_clk_d;
  logic             spi_mosi_q, spi_mosi_d;
  logic             spi_cs_q, spi_cs_d;

  logic        acc, wr, rd, expire, tail_done;
  logic [31:0] ctrl_rd;
  logic        unused_wdata;

  assign unused_wdata = ^wdata;

  always_comb begin
    acc       = sel && !ready_q && !acked_q;
    wr        = acc && we;
    rd        = acc && !we;
    expire    = (state_q != IDLE) && (cnt_q == '0);
    tail_done = expire && (state_q == TAIL);

    state_d    = state_q;
    cnt_d      = (state_q != IDLE) ? cnt_q - DIV_W'(1) : cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    miso_d     = miso_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    cs_force_d = cs_force_q;
    irq_en_d   = irq_en_q;
    ready_d    = acc;
    // A new access is only accepted once sel has been sampled low after ready.
    acked_d    = (ready_q || acked_q) && sel;

    ctrl_rd            = '0;
    ctrl_rd[DIV_W-1:0] = div_q;
    ctrl_rd[8]         = cs_force_q;
    ctrl_rd[9]         = irq_en_q;

    rdata_d = '0;
    if (rd) begin
      case (addr)
        ADDR_CTRL:   rdata_d = ctrl_rd;
        ADDR_DATA:   rdata_d = {24'd0, tail_done ? shift_q : rx_q};
        ADDR_STATUS: rdata_d = {29'd0, ovr_q, done_q, busy_q};
        default:     rdata_d = '0;
      endcase
    end

    if (wr && addr == ADDR_CTRL) begin
      div_d      = wdata[DIV_W-1:0];
      cs_force_d = wdata[8];
      irq_en_d   = wdata[9];
    end
    if (wr && addr == ADDR_STATUS) begin
      if (wdata[1]) done_d = 1'b0;
      if (wdata[2]) ovr_d  = 1'b0;
    end
    if (rd && addr == ADDR_DATA) done_d = 1'b0;
    if (wr && addr == ADDR_DATA && busy_q) ovr_d = 1'b1;

    // Sequencer runs after the register clears so a same-cycle done set wins.
    case (state_q)
      IDLE: begin
        if (wr && addr == ADDR_DATA && !busy_q) begin
          state_d = LOW;
          cnt_d   = div_q;
          shift_d = wdata[7:0];
          bit_d   = 3'd0;
          busy_d  = 1'b1;
        end
      end
      LOW: begin
        if (expire) begin
          state_d = HIGH;
          cnt_d   = div_q;
          miso_d  = spi_miso;
        end
      end
      HIGH: begin
        if (expire) begin
          shift_d = {shift_q[6:0], miso_q};
          cnt_d   = div_q;
          if (bit_q == 3'd7) begin
            state_d = TAIL;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = LOW;
          end
        end
      end
      TAIL: begin
        if (expire) begin
          rx_d    = shift_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    spi_clk_d  = (state_d == HIGH);
    spi_mosi_d = (state_d == LOW || state_d == HIGH) ? shift_d[7] : 1'b0;
    spi_cs_d   = !(cs_force_d || busy_d);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_RST;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      rx_q       <= 8'd0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      cs_force_q <= 1'b0;
      irq_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      acked_q    <= 1'b0;
      rdata_q    <= '0;
      spi_clk_q  <= 1'b0;
      spi_mosi_q <= 1'b0;
      spi_cs_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      cs_force_q <= cs_force_d;
      irq_en_q   <= irq_en_d;
      ready_q    <= ready_d;
      acked_q    <= acked_d;
      rdata_q    <= rdata_d;
      spi_clk_q  <= spi_clk_d;
      spi_mosi_q <= spi_mosi_d;
      spi_cs_q   <= spi_cs_d;
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign spi_clk  = spi_clk_q;
  assign spi_mosi = spi_mosi_q;
  assign spi_cs   = spi_cs_q;
  assign irq      = done_q && irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_ctrl : directed self-checking bench for spi_ctrl                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_spi_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs;
  logic        irq;

  logic loop_en  = 1'b1;
  logic miso_val = 1'b0;
  assign spi_miso = loop_en ? spi_mosi : miso_val;

  int checks   = 0;
  int failures = 0;

  logic irq_at_ready;
  logic cs_watch    = 1'b0;
  int   cs_high_cnt = 0;

  int         cs_low, pulses, hi_len, lo_len;
  logic [7:0] bits;
  logic       irq_before, timed_out;

  spi_ctrl #(.DIV_W(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs   (spi_cs),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cs_watch && spi_cs === 1'b1) cs_high_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus access: idle cycle, drive, expect ready on the next cycle.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input string tag, output logic [31:0] v);
    @(posedge clk); #1;
    check({tag, "_rdy_low"}, {31'd0, ready}, 32'd0);
    sel = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    v = rdata;
    irq_at_ready = irq;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
    logic [31:0] v;
    bus(1'b1, a, d, tag, v);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus(1'b0, a, 32'd0, tag, v);
    check(tag, v, exp);
  endtask

  task automatic observe(input int budget);
    logic prev_clk;
    cs_low = 0; pulses = 0; bits = 8'd0; hi_len = 0; lo_len = 0;
    irq_before = 1'b0; timed_out = 1'b1; prev_clk = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (spi_cs) begin
        if (cs_low > 0) begin
          timed_out = 1'b0;
          break;
        end
      end else begin
        cs_low++;
        irq_before = irq;
      end
      if (spi_clk && !prev_clk) begin
        pulses++;
        bits = {bits[6:0], spi_mosi};
      end
      if (pulses == 1) begin
        if (spi_clk) hi_len++;
        else lo_len++;
      end
      prev_clk = spi_clk;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    resetn = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs",    {31'd0, spi_cs},   32'd1);
    check("rst_clk",   {31'd0, spi_clk},  32'd0);
    check("rst_mosi",  {31'd0, spi_mosi}, 32'd0);
    check("rst_ready", {31'd0, ready},    32'd0);
    check("rst_rdata", rdata,             32'd0);
    check("rst_irq",   {31'd0, irq},      32'd0);
    resetn = 1'b1;
    rd_chk(2'd0, 32'h003, "rst_ctrl");
    rd_chk(2'd2, 32'h000, "rst_status");
    rd_chk(2'd1, 32'h000, "rst_data");

    // div=0 loopback of 0xA5
    wr(2'd0, 32'h000, "div0");
    loop_en = 1'b1;
    wr(2'd1, 32'hA5, "a5_wr");
    observe(200);
    check("a5_timeout", {31'd0, timed_out}, 32'd0);
    check("a5_busy",    cs_low,  17);
    check("a5_pulses",  pulses,  8);
    check("a5_mosi",    {24'd0, bits}, 32'hA5);
    check("a5_hi",      hi_len,  1);
    check("a5_lo",      lo_len,  1);
    check("a5_irq_off", {31'd0, irq}, 32'd0);
    rd_chk(2'd2, 32'h2, "a5_status_done");
    rd_chk(2'd1, 32'hA5, "a5_rx");
    rd_chk(2'd2, 32'h0, "a5_status_clr");

    // DATA read accepted on the very edge the byte is latched
    wr(2'd1, 32'h5A, "5a_wr");
    repeat (15) @(posedge clk);
    rd_chk(2'd1, 32'h5A, "same_cycle_rx");
    rd_chk(2'd2, 32'h2,  "set_wins");
    rd_chk(2'd1, 32'h5A, "5a_rx_again");
    rd_chk(2'd2, 32'h0,  "5a_status_clr");

    // div=3, MISO tied high
    wr(2'd0, 32'h003, "div3");
    loop_en = 1'b0; miso_val = 1'b1;
    wr(2'd1, 32'h00, "ff_wr");
    observe(400);
    check("ff_timeout", {31'd0, timed_out}, 32'd0);
    check("ff_busy",    cs_low, 68);
    check("ff_pulses",  pulses, 8);
    check("ff_mosi",    {24'd0, bits}, 32'h00);
    check("ff_hi",      hi_len, 4);
    check("ff_lo",      lo_len, 4);
    rd_chk(2'd1, 32'hFF, "ff_rx");

    // Write while busy is dropped and flags overrun
    loop_en = 1'b1;
    wr(2'd1, 32'h11, "ovr_first");
    wr(2'd1, 32'h22, "ovr_second");
    observe(400);
    check("ovr_timeout", {31'd0, timed_out}, 32'd0);
    rd_chk(2'd2, 32'h6, "ovr_status");
    wr(2'd2, 32'h4, "ovr_clr");
    rd_chk(2'd2, 32'h2,  "ovr_status_clr");
    rd_chk(2'd1, 32'h11, "ovr_rx");
    rd_chk(2'd2, 32'h0,  "ovr_status_final");

    // Interrupt
    wr(2'd0, 32'h200, "irq_en");
    wr(2'd1, 32'h3C, "irq_wr");
    observe(200);
    check("irq_timeout",  {31'd0, timed_out},  32'd0);
    check("irq_before",   {31'd0, irq_before}, 32'd0);
    check("irq_rise",     {31'd0, irq},        32'd1);
    rd_chk(2'd1, 32'h3C, "irq_rx");
    check("irq_drop_rdy", {31'd0, irq_at_ready}, 32'd0);

    // Forced chip select across back-to-back transfers
    wr(2'd0, 32'h100, "csf_on");
    check("csf_cs_low", {31'd0, spi_cs}, 32'd0);
    cs_watch = 1'b1;
    wr(2'd1, 32'h81, "csf_wr1");
    repeat (20) @(posedge clk);
    wr(2'd1, 32'h7E, "csf_wr2");
    repeat (20) @(posedge clk);
    rd_chk(2'd1, 32'h7E, "csf_rx");
    check("csf_cs_hold", {31'd0, spi_cs}, 32'd0);
    cs_watch = 1'b0;
    check("csf_no_glitch", cs_high_cnt, 0);
    wr(2'd0, 32'h000, "csf_off");
    check("csf_release", {31'd0, spi_cs}, 32'd1);

    // Reset in the high phase of bit 4
    wr(2'd0, 32'h203, "rst_mid_ctrl");
    wr(2'd1, 32'hFF, "rst_mid_wr");
    repeat (37) @(posedge clk);
    #1;
    check("mid_cs",   {31'd0, spi_cs},   32'd0);
    check("mid_clk",  {31'd0, spi_clk},  32'd1);
    check("mid_mosi", {31'd0, spi_mosi}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("abort_cs",   {31'd0, spi_cs},   32'd1);
    check("abort_clk",  {31'd0, spi_clk},  32'd0);
    check("abort_mosi", {31'd0, spi_mosi}, 32'd0);
    check("abort_irq",  {31'd0, irq},      32'd0);
    resetn = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("abort_irq_late", {31'd0, irq}, 32'd0);
    rd_chk(2'd2, 32'h0,   "abort_status");
    rd_chk(2'd0, 32'h003, "abort_ctrl");

    // Held sel yields a single ready pulse
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b0; addr = 2'd2;
    @(posedge clk); #1;
    check("hold_rdy",   {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    check("hold_rdy_2", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    check("hold_rdy_3", {31'd0, ready}, 32'd0);
    sel = 1'b0;
    rd_chk(2'd0, 32'h003, "hold_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
